pdpm_rx_parser: RTL and testbench
=================================

# pdpm_rx_parser

Memory-side receiver for the byte-wide AXI-Stream arriving from the Ethernet MAC RX FIFO. It strips the Ethernet header and decodes the pDPM request header. It then issues one command per valid frame to the memory engine and forwards WRITE payload bytes on a separate AXI-Stream. Malformed frames are dropped whole, flagged on error pulses, and never generate a command.

## Interface
- ETHERTYPE, 16'h88B5, required EtherType (bytes 12–13, big-endian)
- MAX_LEN, 1024, largest legal request length in bytes
- s_axis_aclk  in  1  sole clock
- s_axis_aresetn  in  1  asynchronous, active-low reset
- s_axis_tdata / s_axis_tvalid / s_axis_tlast  in  8/1/1  frame bytes from the network
- s_axis_tready  out  1  parser accepts a byte
- cmd_valid / cmd_ready  out/in  1/1  command handshake
- cmd_op  out  8  0x01 READ, 0x02 WRITE
- cmd_tag  out  8  request tag, echoed in the reply
- cmd_addr  out  32  byte address
- cmd_len  out  16  byte count
- cmd_src_mac  out  48  requester MAC (bytes 6–11)
- m_axis_tdata / m_axis_tvalid / m_axis_tlast / m_axis_tready  out/out/out/in  8/1/1/1  WRITE payload
- err_valid  out  1  one-cycle pulse: frame dropped
- err_code  out  2  0 runt, 1 bad EtherType, 2 bad opcode, 3 length > MAX_LEN
- err_trunc  out  1  one-cycle pulse: WRITE payload ended early
- stat_ok / stat_drop / stat_trunc  out  32 each  frame counters (see Configuration)

## Operation
- Frame layout (byte index):
  - 0–5: dst MAC
  - 6–11: src MAC
  - 12–13: EtherType
  - 14: opcode
  - 15: tag
  - 16–19: addr, MSB first
  - 20–21: len, MSB first
  - 22 onward: payload, then padding
- States: HDR, CMD, DATA, DRAIN. Byte counter is 5 bits; it resets to 0 on every frame start.
- HDR:
  - s_axis_tready=1. Each accepted byte is latched into its field.
  - Checks happen on the byte that completes the field: EtherType at index 13, opcode at 14, len at 21.
  - The first failing check pulses err_valid with its code. The parser then goes to DRAIN, or stays in HDR if that byte carries tlast.
  - tlast before index 21 with no prior failure: runt (code 0), stay in HDR.
  - Index 21 accepted with all checks passing: go to CMD.
  - Exception: a WRITE with len>0 whose index-21 byte carries tlast gives err_trunc, no command, stay in HDR.
- CMD:
  - s_axis_tready=0, cmd_valid=1, all cmd_* fields stable.
  - On cmd_ready:
    - WRITE with len>0: go to DATA.
    - Otherwise, if the frame already ended: go to HDR.
    - Otherwise: go to DRAIN.
- DATA:
  - m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready (combinational pass-through).
  - A 16-bit remaining counter is loaded with len and decrements per transfer.
  - When the counter reaches 1: that beat carries m_axis_tlast=1. Go to HDR if s_axis_tlast is also set, otherwise to DRAIN.
  - s_axis_tlast with counter >1: forward that beat with m_axis_tlast=1, pulse err_trunc, go to HDR.
- DRAIN: s_axis_tready=1, bytes discarded. s_axis_tlast goes to HDR.
- READ: payload and padding are always discarded.
- len=0 is legal for both opcodes; it issues a command with no data beats.

## Timing
- Reset (asynchronous): state HDR, counters 0, all outputs 0.
- s_axis_tready rises on the first clock edge after reset release.
- cmd_valid rises the cycle after index 21 is accepted.
- Payload path has zero latency. Back-to-back frames lose one cycle in CMD at minimum.
- err_valid and err_trunc are registered; they fire the cycle after the offending byte.
- Reset mid-frame abandons the frame. Resumed bytes are parsed as a new frame and normally drop on the EtherType check.
- m_axis_tvalid never rises outside DATA.

## Configuration
- PDPM_RX_STATS_EN defined:
  - stat_ok counts commands issued.
  - stat_drop counts err_valid pulses.
  - stat_trunc counts err_trunc pulses.
  - Each counter is 32-bit, saturating at all-ones, cleared only by reset.
- Undefined: stat_* are tied to 0 and no counter logic is synthesised.

## Structure
- pdpm_pkg holds:
  - opcode constants, ETH_HDR_LEN=14, PDPM_HDR_LEN=22
  - err_code values
  - the parser state enum
- Sub-module pdpm_rx_stats holds the three saturating counters. It is instantiated only under PDPM_RX_STATS_EN.

## Test plan
- READ frame, addr 0x00001000, len 64, tag 0x5A, 60 bytes total -> one command with op 0x01, addr 0x1000, len 64, tag 0x5A, correct src MAC; no m_axis beats.
- WRITE, len 4, payload DE AD BE EF plus 34 padding bytes, m_axis_tready toggling every cycle -> 4 beats in order, tlast on 0xEF, padding drained, next frame parsed cleanly.
- EtherType 0x0800 -> err_valid with code 1, no command, rest of frame drained; WRITE with len 1025 -> code 3.
- 10-byte frame -> code 0; WRITE len 8 whose tlast arrives after 3 payload bytes -> 3 beats, tlast on 3rd, err_trunc.
- cmd_ready held low 20 cycles -> s_axis_tready=0 throughout, cmd fields stable; reset asserted mid-payload -> outputs 0 immediately, HDR afterwards.
- PDPM_RX_STATS_EN defined, 3 good, 2 bad, 1 truncated frame -> stat_ok=3, stat_drop=2, stat_trunc=1.

Source files
------------

// File: rtl/pdpm_pkg.sv
// pdpm_pkg: shared constants, error codes, parser state enum and helpers for
// the pDPM receive parser.
package pdpm_pkg;

    localparam logic [15:0] ETHERTYPE    = 16'h88B5;
    localparam logic [15:0] MAX_LEN      = 16'd1024;

    localparam logic [7:0]  OP_READ      = 8'h01;
    localparam logic [7:0]  OP_WRITE     = 8'h02;

    localparam int          ETH_HDR_LEN  = 14;
    localparam int          PDPM_HDR_LEN = 22;

    // Byte indices on which each header check completes
    localparam logic [4:0]  IDX_ETYPE_LO = 5'(ETH_HDR_LEN - 1);
    localparam logic [4:0]  IDX_OPCODE   = 5'(ETH_HDR_LEN);
    localparam logic [4:0]  IDX_LEN_LO   = 5'(PDPM_HDR_LEN - 1);

    typedef enum logic [1:0] {
        ERR_RUNT   = 2'd0,
        ERR_ETYPE  = 2'd1,
        ERR_OPCODE = 2'd2,
        ERR_LEN    = 2'd3
    } err_code_t;

    typedef enum logic [1:0] {
        ST_HDR   = 2'd0,
        ST_CMD   = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } rx_state_t;

    function automatic logic op_is_valid(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : (val + 32'd1);
    endfunction

endpackage

// File: rtl/pdpm_rx_parser_if.sv
// pdpm_rx_parser_if: byte-wide AXI-Stream bundle used for both the network
// input and the WRITE payload output of the parser.
interface pdpm_rx_parser_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/pdpm_rx_stats.sv
// pdpm_rx_stats: three 32-bit saturating frame counters, cleared by reset only.
module pdpm_rx_stats
    import pdpm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_ok,
    input  logic        inc_drop,
    input  logic        inc_trunc,
    output logic [31:0] stat_ok,
    output logic [31:0] stat_drop,
    output logic [31:0] stat_trunc
);

    logic [31:0] ok_r;
    logic [31:0] drop_r;
    logic [31:0] trunc_r;

    // Count events, holding at all-ones once saturated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_r    <= 32'd0;
            drop_r  <= 32'd0;
            trunc_r <= 32'd0;
        end else begin
            if (inc_ok)    ok_r    <= sat_inc(ok_r);
            if (inc_drop)  drop_r  <= sat_inc(drop_r);
            if (inc_trunc) trunc_r <= sat_inc(trunc_r);
        end
    end

    assign stat_ok    = ok_r;
    assign stat_drop  = drop_r;
    assign stat_trunc = trunc_r;

endmodule

// File: rtl/pdpm_rx_parser.sv
// pdpm_rx_parser: strips the Ethernet header, decodes the pDPM request header,
// issues one command per good frame and forwards WRITE payload bytes.
// Optional statistics counters are built when PDPM_RX_STATS_EN is defined.
module pdpm_rx_parser
    import pdpm_pkg::*;
(
    input  logic                     s_axis_aclk,
    input  logic                     s_axis_aresetn,
    pdpm_rx_parser_if.slave          s_axis,
    pdpm_rx_parser_if.master         m_axis,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [7:0]               cmd_op,
    output logic [7:0]               cmd_tag,
    output logic [31:0]              cmd_addr,
    output logic [15:0]              cmd_len,
    output logic [47:0]              cmd_src_mac,
    output logic                     err_valid,
    output logic [1:0]               err_code,
    output logic                     err_trunc,
    output logic [31:0]              stat_ok,
    output logic [31:0]              stat_drop,
    output logic [31:0]              stat_trunc
);

    rx_state_t   state_r;
    rx_state_t   state_n;

    logic        armed_r;      // low only until the first edge after reset
    logic [4:0]  idx_r;
    logic        done_r;       // frame's tlast already seen when entering CMD
    logic [7:0]  et_hi_r;
    logic [7:0]  len_hi_r;
    logic [7:0]  op_r;
    logic [7:0]  tag_r;
    logic [31:0] addr_r;
    logic [15:0] len_r;
    logic [47:0] src_r;
    logic [15:0] rem_r;
    logic        err_valid_r;
    logic [1:0]  err_code_r;
    logic        err_trunc_r;

    logic        hdr_acc_s;
    logic        data_xfer_s;
    logic        s_ready_s;
    logic        err_s;
    err_code_t   err_code_s;
    logic        trunc_s;
    logic [15:0] et_s;
    logic [15:0] len_s;

    assign et_s        = {et_hi_r, s_axis.tdata};
    assign len_s       = {len_hi_r, s_axis.tdata};
    assign hdr_acc_s   = (state_r == ST_HDR) && armed_r && s_axis.tvalid;
    assign data_xfer_s = (state_r == ST_DATA) && s_axis.tvalid && m_axis.tready;

    // State register
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_r <= ST_HDR;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state decode, header checks and handshake control
    always_comb begin
        state_n    = state_r;
        s_ready_s  = 1'b0;
        err_s      = 1'b0;
        err_code_s = ERR_RUNT;
        trunc_s    = 1'b0;
        case (state_r)
            ST_HDR: begin
                s_ready_s = armed_r;
                if (hdr_acc_s) begin
                    if ((idx_r == IDX_ETYPE_LO) && (et_s != ETHERTYPE)) begin
                        err_s      = 1'b1;
                        err_code_s = ERR_ETYPE;
                    end else if ((idx_r == IDX_OPCODE) && !op_is_valid(s_axis.tdata)) begin
                        err_s      = 1'b1;
                        err_code_s = ERR_OPCODE;
                    end else if ((idx_r == IDX_LEN_LO) && (len_s > MAX_LEN)) begin
                        err_s      = 1'b1;
                        err_code_s = ERR_LEN;
                    end else if (s_axis.tlast && (idx_r != IDX_LEN_LO)) begin
                        err_s      = 1'b1;
                        err_code_s = ERR_RUNT;
                    end else if (idx_r == IDX_LEN_LO) begin
                        if (s_axis.tlast && (op_r == OP_WRITE) && (len_s != 16'd0)) begin
                            trunc_s = 1'b1;
                        end else begin
                            state_n = ST_CMD;
                        end
                    end else begin
                        state_n = ST_HDR;
                    end
                    if (err_s && !s_axis.tlast) begin
                        state_n = ST_DRAIN;
                    end else begin
                        state_n = state_n;
                    end
                end else begin
                    state_n = ST_HDR;
                end
            end
            ST_CMD: begin
                if (cmd_ready) begin
                    if ((op_r == OP_WRITE) && (len_r != 16'd0)) begin
                        state_n = ST_DATA;
                    end else if (done_r) begin
                        state_n = ST_HDR;
                    end else begin
                        state_n = ST_DRAIN;
                    end
                end else begin
                    state_n = ST_CMD;
                end
            end
            ST_DATA: begin
                s_ready_s = m_axis.tready;
                if (data_xfer_s) begin
                    if (rem_r == 16'd1) begin
                        state_n = s_axis.tlast ? ST_HDR : ST_DRAIN;
                    end else if (s_axis.tlast) begin
                        trunc_s = 1'b1;
                        state_n = ST_HDR;
                    end else begin
                        state_n = ST_DATA;
                    end
                end else begin
                    state_n = ST_DATA;
                end
            end
            ST_DRAIN: begin
                s_ready_s = 1'b1;
                if (s_axis.tvalid && s_axis.tlast) begin
                    state_n = ST_HDR;
                end else begin
                    state_n = ST_DRAIN;
                end
            end
            default: begin
                state_n = ST_HDR;
            end
        endcase
    end

    // Arm input acceptance and track the header byte index
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            armed_r <= 1'b0;
            idx_r   <= 5'd0;
            done_r  <= 1'b0;
        end else begin
            armed_r <= 1'b1;
            if (hdr_acc_s) begin
                done_r <= s_axis.tlast;
                if (s_axis.tlast || (idx_r == IDX_LEN_LO)) begin
                    idx_r <= 5'd0;
                end else begin
                    idx_r <= idx_r + 5'd1;
                end
            end else if (state_r != ST_HDR) begin
                idx_r <= 5'd0;
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Latch header fields as their bytes arrive
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            src_r    <= 48'd0;
            et_hi_r  <= 8'd0;
            op_r     <= 8'd0;
            tag_r    <= 8'd0;
            addr_r   <= 32'd0;
            len_hi_r <= 8'd0;
            len_r    <= 16'd0;
        end else if (hdr_acc_s) begin
            if ((idx_r >= 5'd6) && (idx_r <= 5'd11)) begin
                src_r <= {src_r[39:0], s_axis.tdata};
            end else if (idx_r == 5'd12) begin
                et_hi_r <= s_axis.tdata;
            end else if (idx_r == IDX_OPCODE) begin
                op_r <= s_axis.tdata;
            end else if (idx_r == 5'd15) begin
                tag_r <= s_axis.tdata;
            end else if ((idx_r >= 5'd16) && (idx_r <= 5'd19)) begin
                addr_r <= {addr_r[23:0], s_axis.tdata};
            end else if (idx_r == 5'd20) begin
                len_hi_r <= s_axis.tdata;
            end else if (idx_r == IDX_LEN_LO) begin
                len_r <= len_s;
            end else begin
                src_r <= src_r;
            end
        end
    end

    // Remaining-payload counter for WRITE data beats
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            rem_r <= 16'd0;
        end else if ((state_r == ST_CMD) && cmd_ready) begin
            rem_r <= len_r;
        end else if (data_xfer_s) begin
            rem_r <= rem_r - 16'd1;
        end else begin
            rem_r <= rem_r;
        end
    end

    // Registered error pulses, one cycle after the offending byte
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            err_valid_r <= 1'b0;
            err_code_r  <= 2'd0;
            err_trunc_r <= 1'b0;
        end else begin
            err_valid_r <= err_s;
            err_code_r  <= err_s ? err_code_s : err_code_r;
            err_trunc_r <= trunc_s;
        end
    end

    assign s_axis.tready = s_ready_s;

    assign m_axis.tdata  = (state_r == ST_DATA) ? s_axis.tdata : 8'd0;
    assign m_axis.tvalid = (state_r == ST_DATA) && s_axis.tvalid;
    assign m_axis.tlast  = (state_r == ST_DATA) && ((rem_r == 16'd1) || s_axis.tlast);

    assign cmd_valid   = (state_r == ST_CMD);
    assign cmd_op      = op_r;
    assign cmd_tag     = tag_r;
    assign cmd_addr    = addr_r;
    assign cmd_len     = len_r;
    assign cmd_src_mac = src_r;

    assign err_valid = err_valid_r;
    assign err_code  = err_code_r;
    assign err_trunc = err_trunc_r;

`ifdef PDPM_RX_STATS_EN
    pdpm_rx_stats u_stats (
        .clk        (s_axis_aclk),
        .rst_n      (s_axis_aresetn),
        .inc_ok     (cmd_valid && cmd_ready),
        .inc_drop   (err_valid_r),
        .inc_trunc  (err_trunc_r),
        .stat_ok    (stat_ok),
        .stat_drop  (stat_drop),
        .stat_trunc (stat_trunc)
    );
`else
    assign stat_ok    = 32'd0;
    assign stat_drop  = 32'd0;
    assign stat_trunc = 32'd0;
`endif

endmodule

// File: tb/tb_pdpm_rx_parser.sv
// Scoreboard bench for pdpm_rx_parser: stimulus pushes expected commands,
// payload beats and error events; a negedge monitor pops and compares.
module tb_pdpm_rx_parser;
    import pdpm_pkg::*;

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  tag;
        logic [31:0] addr;
        logic [15:0] len;
    } cmd_t;

    localparam logic [47:0] SRC_MAC = 48'h02_11_22_33_44_55;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [7:0]  cmd_op;
    logic [7:0]  cmd_tag;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic [47:0] cmd_src_mac;
    logic        err_valid;
    logic [1:0]  err_code;
    logic        err_trunc;
    logic [31:0] stat_ok;
    logic [31:0] stat_drop;
    logic [31:0] stat_trunc;
    logic        toggle_en;

    pdpm_rx_parser_if s_if ();
    pdpm_rx_parser_if m_if ();

    pdpm_rx_parser dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_tag        (cmd_tag),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_src_mac    (cmd_src_mac),
        .err_valid      (err_valid),
        .err_code       (err_code),
        .err_trunc      (err_trunc),
        .stat_ok        (stat_ok),
        .stat_drop      (stat_drop),
        .stat_trunc     (stat_trunc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int exp_ok = 0;
    int exp_drop = 0;
    int exp_trunc = 0;

    cmd_t       cmd_q[$];
    logic [8:0] data_q[$];   // {tlast, byte}
    logic [2:0] ev_q[$];     // 0..3 err_code, 4 truncation
    logic [7:0] fr[$];

    cmd_t       mon_c;
    logic [8:0] mon_d;
    logic [2:0] mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid && cmd_ready) begin
                if (cmd_q.size() == 0) begin
                    chk("cmd_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_c = cmd_q.pop_front();
                    chk("cmd_op", 64'(cmd_op), 64'(mon_c.op));
                    chk("cmd_tag", 64'(cmd_tag), 64'(mon_c.tag));
                    chk("cmd_addr", 64'(cmd_addr), 64'(mon_c.addr));
                    chk("cmd_len", 64'(cmd_len), 64'(mon_c.len));
                    chk("cmd_src_mac", 64'(cmd_src_mac), 64'(SRC_MAC));
                end
            end
            if (m_if.tvalid && m_if.tready) begin
                if (data_q.size() == 0) begin
                    chk("data_unexpected", 64'(m_if.tdata), 64'h1FF);
                end else begin
                    mon_d = data_q.pop_front();
                    chk("data_beat", 64'({m_if.tlast, m_if.tdata}), 64'(mon_d));
                end
            end
            if (err_valid || err_trunc) begin
                if (ev_q.size() == 0) begin
                    chk("event_unexpected", 64'({err_trunc, err_code}), 64'h7);
                end else begin
                    mon_e = ev_q.pop_front();
                    chk("event", err_trunc ? 64'd4 : 64'(err_code), 64'(mon_e));
                end
            end
        end
    end

    // Payload sink ready: held high, or toggled each cycle when enabled
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_if.tready = toggle_en ? ~m_if.tready : 1'b1;
        end
    end

    task automatic build(input logic [15:0] et, input logic [7:0] op, input logic [7:0] tag,
                         input logic [31:0] addr, input logic [15:0] len);
        logic [47:0] src;
        src = SRC_MAC;
        fr.delete();
        for (int i = 0; i < 6; i++) fr.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 6; i++) fr.push_back(src[47 - 8*i -: 8]);
        fr.push_back(et[15:8]);
        fr.push_back(et[7:0]);
        fr.push_back(op);
        fr.push_back(tag);
        for (int i = 0; i < 4; i++) fr.push_back(addr[31 - 8*i -: 8]);
        fr.push_back(len[15:8]);
        fr.push_back(len[7:0]);
    endtask

    task automatic pad(input int n);
        for (int i = 0; i < n; i++) fr.push_back(8'hA0 + 8'(i));
    endtask

    task automatic exp_cmd(input logic [7:0] op, input logic [7:0] tag,
                           input logic [31:0] addr, input logic [15:0] len);
        cmd_t c;
        c.op = op; c.tag = tag; c.addr = addr; c.len = len;
        cmd_q.push_back(c);
        exp_ok++;
    endtask

    task automatic exp_ev(input logic [2:0] code);
        ev_q.push_back(code);
        if (code == 3'd4) exp_trunc++;
        else exp_drop++;
    endtask

    // Present each byte of fr, waiting (bounded) for acceptance
    task automatic send(input bit with_last);
        for (int i = 0; i < fr.size(); i++) begin
            int  n;
            bit  acc;
            s_if.tdata  = fr[i];
            s_if.tvalid = 1'b1;
            s_if.tlast  = with_last && (i == fr.size() - 1);
            n = 0;
            acc = 1'b0;
            while (!acc && n < 300) begin
                @(negedge clk);
                acc = s_if.tready;
                @(posedge clk);
                #1;
                n++;
            end
            if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_s_tready", 64'(s_if.tready), 64'd0);
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("rst_errs", 64'({err_valid, err_trunc, err_code}), 64'd0);
        chk("rst_stats", 64'(stat_ok | stat_drop | stat_trunc), 64'd0);
        exp_ok = 0; exp_drop = 0; exp_trunc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_s_tready_low", 64'(s_if.tready), 64'd0);
        @(posedge clk);
        #1;
        chk("rel_s_tready_high", 64'(s_if.tready), 64'd1);
    endtask

    initial begin
        int          n;
        logic [31:0] want_ok, want_drop, want_trunc;
        s_if.tdata = 8'd0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
        cmd_ready = 1'b1;
        toggle_en = 1'b0;
        rst_n = 1'b1;
        #3;
        do_reset();

        // READ, 60 bytes total
        build(ETHERTYPE, OP_READ, 8'h5A, 32'h0000_1000, 16'd64); pad(38);
        exp_cmd(OP_READ, 8'h5A, 32'h0000_1000, 16'd64);
        send(1'b1);

        // Reset in the middle of a WRITE payload
        build(ETHERTYPE, OP_WRITE, 8'h01, 32'h0000_0040, 16'd8);
        fr.push_back(8'h11); fr.push_back(8'h22);
        exp_cmd(OP_WRITE, 8'h01, 32'h0000_0040, 16'd8);
        data_q.push_back({1'b0, 8'h11});
        data_q.push_back({1'b0, 8'h22});
        send(1'b0);
        do_reset();

        // READ after reset parses cleanly from HDR
        build(ETHERTYPE, OP_READ, 8'h77, 32'h1234_5678, 16'd8); pad(4);
        exp_cmd(OP_READ, 8'h77, 32'h1234_5678, 16'd8);
        send(1'b1);

        // WRITE DE AD BE EF with toggling payload ready
        toggle_en = 1'b1;
        build(ETHERTYPE, OP_WRITE, 8'hC3, 32'h0000_2000, 16'd4);
        fr.push_back(8'hDE); fr.push_back(8'hAD); fr.push_back(8'hBE); fr.push_back(8'hEF);
        pad(34);
        exp_cmd(OP_WRITE, 8'hC3, 32'h0000_2000, 16'd4);
        data_q.push_back({1'b0, 8'hDE});
        data_q.push_back({1'b0, 8'hAD});
        data_q.push_back({1'b0, 8'hBE});
        data_q.push_back({1'b1, 8'hEF});
        send(1'b1);
        toggle_en = 1'b0;

        // WRITE with len 0: command, no beats
        build(ETHERTYPE, OP_WRITE, 8'h09, 32'h0000_3000, 16'd0); pad(10);
        exp_cmd(OP_WRITE, 8'h09, 32'h0000_3000, 16'd0);
        send(1'b1);

        // Bad EtherType
        build(16'h0800, OP_READ, 8'h01, 32'h0, 16'd4); pad(38);
        exp_ev(3'd1);
        send(1'b1);

        // Length one past the maximum
        build(ETHERTYPE, OP_WRITE, 8'h02, 32'h0, 16'd1025); pad(38);
        exp_ev(3'd3);
        send(1'b1);

        // Bad opcode
        build(ETHERTYPE, 8'h07, 8'h03, 32'h0, 16'd4); pad(20);
        exp_ev(3'd2);
        send(1'b1);

        // 10-byte runt
        build(ETHERTYPE, OP_READ, 8'h04, 32'h0, 16'd4);
        while (fr.size() > 10) void'(fr.pop_back());
        exp_ev(3'd0);
        send(1'b1);

        // WRITE len 8 truncated after 3 payload bytes
        build(ETHERTYPE, OP_WRITE, 8'h44, 32'h0000_4000, 16'd8);
        fr.push_back(8'h31); fr.push_back(8'h32); fr.push_back(8'h33);
        exp_cmd(OP_WRITE, 8'h44, 32'h0000_4000, 16'd8);
        data_q.push_back({1'b0, 8'h31});
        data_q.push_back({1'b0, 8'h32});
        data_q.push_back({1'b1, 8'h33});
        exp_ev(3'd4);
        send(1'b1);

        // WRITE whose frame ends on the last header byte
        build(ETHERTYPE, OP_WRITE, 8'h55, 32'h0000_5000, 16'd4);
        exp_ev(3'd4);
        send(1'b1);

        // Command back-pressure for 20 cycles
        cmd_ready = 1'b0;
        build(ETHERTYPE, OP_READ, 8'h33, 32'hCAFE_0000, 16'd16); pad(10);
        exp_cmd(OP_READ, 8'h33, 32'hCAFE_0000, 16'd16);
        fork
            send(1'b1);
        join_none
        n = 0;
        while (!cmd_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_cmd_seen", 64'(cmd_valid), 64'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_s_tready", 64'(s_if.tready), 64'd0);
            chk("stall_fields", 64'({cmd_valid, cmd_tag, cmd_addr, cmd_len}),
                64'({1'b1, 8'h33, 32'hCAFE_0000, 16'd16}));
        end
        @(posedge clk);
        #1;
        cmd_ready = 1'b1;
        wait fork;

        repeat (20) @(posedge clk);
        #1;
        chk("cmd_q_empty", 64'(cmd_q.size()), 64'd0);
        chk("data_q_empty", 64'(data_q.size()), 64'd0);
        chk("ev_q_empty", 64'(ev_q.size()), 64'd0);
`ifdef PDPM_RX_STATS_EN
        want_ok = 32'(exp_ok); want_drop = 32'(exp_drop); want_trunc = 32'(exp_trunc);
`else
        want_ok = 32'd0; want_drop = 32'd0; want_trunc = 32'd0;
`endif
        chk("stat_ok", 64'(stat_ok), 64'(want_ok));
        chk("stat_drop", 64'(stat_drop), 64'(want_drop));
        chk("stat_trunc", 64'(stat_trunc), 64'(want_trunc));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
